lr3_kbd_scan: RTL and testbench

//   Matrix keypad scanner: input-side counterpart of the multiplexed 7-seg display driver.

---
 rtl/lr3_kbd_scan_if.sv | 16 +
 rtl/lr3_kbd_scan.sv | 148 ++++++++++++++
 tb/tb_lr3_kbd_scan.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lr3_kbd_scan_if.sv
// rtl/lr3_kbd_scan_if.sv - keypad matrix lines and accepted-key report between scanner and keypad
interface lr3_kbd_scan_if #(
   parameter int N_COL = 4,
   parameter int N_ROW = 4
);
   localparam int KW = (N_ROW * N_COL > 1) ? $clog2(N_ROW * N_COL) : 1;

   logic [N_ROW-1:0] row;
   logic [N_COL-1:0] col;
   logic [KW-1:0]    key_code;
   logic             key_vld;
   logic             key_held;

   modport master (input row, output col, output key_code, output key_vld, output key_held);
   modport slave  (output row, input col, input key_code, input key_vld, input key_held);
endinterface

// File: rtl/lr3_kbd_scan.sv
// rtl/lr3_kbd_scan.sv - matrix keypad scanner: one active-low column at a time, debounced key report
module lr3_kbd_scan #(
   parameter int N_COL   = 4,
   parameter int N_ROW   = 4,
   parameter int DEB_CNT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_scan_ce,
   lr3_kbd_scan_if.master    kbd
);
   localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
   localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1;
   localparam int KW = (N_ROW * N_COL > 1) ? $clog2(N_ROW * N_COL) : 1;
   localparam int DW = $clog2(DEB_CNT + 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT);
   localparam logic [CW-1:0] COL_LAST = CW'(N_COL - 1);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_col_idx, w_col_idx_nxt;
   logic [RW-1:0]    r_row_idx, w_row_idx_nxt;
   logic [DW-1:0]    r_deb_cnt, w_deb_cnt_nxt;
   logic [DW-1:0]    r_rel_cnt, w_rel_cnt_nxt;
   logic [KW-1:0]    r_key_code, w_key_code_nxt;
   logic             r_key_vld, w_key_vld_nxt;
   logic             r_key_held, w_key_held_nxt;
   logic [N_ROW-1:0] r_row_s1, r_row_s2;

   logic [RW-1:0]    w_dec_row;
   logic             w_any_low;
   logic             w_row_still;
   logic             w_latched_high;
   logic             w_accept;
   logic [CW-1:0]    w_col_inc;
   logic [KW-1:0]    w_accept_code;

   // Lowest-index low row wins: scanning downward lets the smallest index overwrite last.
   always_comb begin
      w_dec_row = '0;
      for (int i = N_ROW - 1; i >= 0; i--) begin
         if (!r_row_s2[i]) w_dec_row = RW'(i);
      end
   end

   assign w_any_low      = ~&r_row_s2;
   assign w_row_still    = w_any_low && (w_dec_row == r_row_idx);
   assign w_latched_high = r_row_s2[r_row_idx];
   assign w_col_inc      = (r_col_idx == COL_LAST) ? '0 : r_col_idx + 1'b1;
   assign w_accept_code  = KW'(w_dec_row) * KW'(N_COL) + KW'(r_col_idx);

   always_comb begin
      w_state_nxt    = r_state;
      w_col_idx_nxt  = r_col_idx;
      w_row_idx_nxt  = r_row_idx;
      w_deb_cnt_nxt  = r_deb_cnt;
      w_rel_cnt_nxt  = r_rel_cnt;
      w_key_code_nxt = r_key_code;
      w_key_vld_nxt  = 1'b0;
      w_key_held_nxt = r_key_held;
      w_accept       = 1'b0;

      if (i_scan_ce) begin
         case (r_state)
            ST_SCAN: begin
               if (w_any_low) begin
                  w_row_idx_nxt = w_dec_row;
                  if (DEB_CNT == 1) begin
                     w_accept = 1'b1;
                  end else begin
                     w_deb_cnt_nxt = DW'(1);
                     w_state_nxt   = ST_DEBOUNCE;
                  end
               end else begin
                  w_col_idx_nxt = w_col_inc;
               end
            end
            ST_DEBOUNCE: begin
               if (w_row_still) begin
                  w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                  if (r_deb_cnt + 1'b1 == DEB_MAX) w_accept = 1'b1;
               end else begin
                  w_deb_cnt_nxt = '0;
                  w_col_idx_nxt = w_col_inc;
                  w_state_nxt   = ST_SCAN;
               end
            end
            ST_HELD: begin
               // Only the latched row is watched; other keys cannot disturb the held one.
               if (w_latched_high) begin
                  if (r_rel_cnt + 1'b1 == DEB_MAX) begin
                     w_rel_cnt_nxt  = '0;
                     w_key_held_nxt = 1'b0;
                     w_col_idx_nxt  = w_col_inc;
                     w_state_nxt    = ST_SCAN;
                  end else begin
                     w_rel_cnt_nxt = r_rel_cnt + 1'b1;
                  end
               end else begin
                  w_rel_cnt_nxt = '0;
               end
            end
            default: w_state_nxt = ST_SCAN;
         endcase
      end

      if (w_accept) begin
         w_key_code_nxt = w_accept_code;
         w_key_vld_nxt  = 1'b1;
         w_key_held_nxt = 1'b1;
         w_deb_cnt_nxt  = '0;
         w_rel_cnt_nxt  = '0;
         w_state_nxt    = ST_HELD;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_SCAN;
         r_col_idx  <= '0;
         r_row_idx  <= '0;
         r_deb_cnt  <= '0;
         r_rel_cnt  <= '0;
         r_key_code <= '0;
         r_key_vld  <= 1'b0;
         r_key_held <= 1'b0;
         r_row_s1   <= '1;
         r_row_s2   <= '1;
      end else begin
         r_state    <= w_state_nxt;
         r_col_idx  <= w_col_idx_nxt;
         r_row_idx  <= w_row_idx_nxt;
         r_deb_cnt  <= w_deb_cnt_nxt;
         r_rel_cnt  <= w_rel_cnt_nxt;
         r_key_code <= w_key_code_nxt;
         r_key_vld  <= w_key_vld_nxt;
         r_key_held <= w_key_held_nxt;
         r_row_s1   <= kbd.row;
         r_row_s2   <= r_row_s1;
      end
   end

   assign kbd.col      = ~(N_COL'(1) << r_col_idx);
   assign kbd.key_code = r_key_code;
   assign kbd.key_vld  = r_key_vld;
   assign kbd.key_held = r_key_held;
endmodule

// File: tb/tb_lr3_kbd_scan.sv
// tb/tb_lr3_kbd_scan.sv - keypad scanner bench: emulated key matrix, behavioural model, directed scenarios
module tb_lr3_kbd_scan;
   localparam int NC  = 4;
   localparam int NR  = 4;
   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;

   lr3_kbd_scan_if #(.N_COL(NC), .N_ROW(NR)) kb ();

   lr3_kbd_scan #(.N_COL(NC), .N_ROW(NR), .DEB_CNT(DEB)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_scan_ce (ce),
      .kbd       (kb)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key pulls its row low while its column is driven low.
   bit pressed [NR][NC];
   always_comb begin
      kb.row = '1;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (pressed[r][c] && !kb.col[c]) kb.row[r] = 1'b0;
   end

   int n_pass  = 0;
   int n_total = 0;
   int pulses  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
   endtask

   typedef struct {
      int             mode;  // 0 scanning, 1 confirming press, 2 key held
      int             col;
      int             row;
      int             cnt;
      int             code;
      bit             vld;
      bit             held;
      logic [NR-1:0]  s1;
      logic [NR-1:0]  s2;
   } mdl_t;

   mdl_t m;
   bit   m_ok = 1'b0;

   function automatic mdl_t mdl_reset();
      mdl_t n;
      n.mode = 0; n.col = 0; n.row = 0; n.cnt = 0; n.code = 0;
      n.vld = 1'b0; n.held = 1'b0; n.s1 = '1; n.s2 = '1;
      return n;
   endfunction

   function automatic mdl_t mdl_step(mdl_t c, logic [NR-1:0] row_in, bit tick, bit r);
      mdl_t n;
      int   low;
      if (r) return mdl_reset();
      n = c;
      n.vld = 1'b0;
      n.s1  = row_in;
      n.s2  = c.s1;
      if (!tick) return n;
      low = -1;
      for (int i = NR - 1; i >= 0; i--) if (c.s2[i] === 1'b0) low = i;
      case (c.mode)
         0: if (low < 0) n.col = (c.col + 1) % NC;
            else begin n.row = low; n.cnt = 1; n.mode = 1; end
         1: if (low == c.row) n.cnt = c.cnt + 1;
            else begin n.mode = 0; n.cnt = 0; n.col = (c.col + 1) % NC; end
         default: if (c.s2[c.row] === 1'b1) begin
               n.cnt = c.cnt + 1;
               if (n.cnt >= DEB) begin
                  n.held = 1'b0; n.mode = 0; n.cnt = 0; n.col = (c.col + 1) % NC;
               end
            end else n.cnt = 0;
      endcase
      if (n.mode == 1 && n.cnt >= DEB) begin
         n.code = n.row * NC + n.col;
         n.vld  = 1'b1;
         n.held = 1'b1;
         n.mode = 2;
         n.cnt  = 0;
      end
      return n;
   endfunction

   function automatic logic [NC-1:0] col_pat(int c);
      logic [NC-1:0] p;
      p = '1;
      p[c] = 1'b0;
      return p;
   endfunction

   always @(posedge clk) begin
      m <= mdl_step(m, kb.row, ce, rst);
      if (rst) m_ok <= 1'b1;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("cyc_col",  32'(kb.col),      32'(col_pat(m.col)));
         chk("cyc_code", 32'(kb.key_code), 32'(m.code));
         chk("cyc_vld",  32'(kb.key_vld),  32'(m.vld));
         chk("cyc_held", 32'(kb.key_held), 32'(m.held));
      end
      if (kb.key_vld === 1'b1) pulses++;
   end

   // One SCAN_CE pulse every fourth clock, returning just after the sampling edge.
   task automatic tick(input int n);
      repeat (n) begin
         repeat (3) @(negedge clk);
         ce = 1'b1;
         @(negedge clk);
         ce = 1'b0;
         #2;
      end
   endtask

   task automatic release_all();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) pressed[r][c] = 1'b0;
   endtask

   logic [3:0] seq [4];

   initial begin
      seq[0] = 4'hE; seq[1] = 4'hD; seq[2] = 4'hB; seq[3] = 4'h7;
      release_all();

      // Reset with a scan tick landing inside it.
      repeat (2) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
      rst = 1'b0;
      #2;
      chk("rst_col",  32'(kb.col),      32'h0000000E);
      chk("rst_code", 32'(kb.key_code), 32'd0);
      chk("rst_held", 32'(kb.key_held), 32'd0);
      chk("rst_vld",  32'(kb.key_vld),  32'd0);

      // Idle scanning walks the columns.
      for (int k = 0; k < 12; k++) begin
         tick(1);
         chk("idle_col", 32'(kb.col), 32'(seq[(k + 1) % 4]));
      end
      chk("idle_pulses", 32'(pulses), 32'd0);
      chk("idle_held",   32'(kb.key_held), 32'd0);

      // Key 9 (row 2, col 1) pressed and held.
      pressed[2][1] = 1'b1;
      tick(4);
      chk("k9_early", 32'(pulses), 32'd0);
      tick(1);
      chk("k9_pulse", 32'(pulses), 32'd1);
      chk("k9_vld",   32'(kb.key_vld), 32'd1);
      chk("k9_code",  32'(kb.key_code), 32'd9);
      chk("k9_held",  32'(kb.key_held), 32'd1);
      tick(2);
      chk("k9_single", 32'(pulses), 32'd1);

      // Second key while held is ignored; release bounce restarts the release count.
      pressed[0][0] = 1'b1;
      tick(3);
      chk("roll_pulses", 32'(pulses), 32'd1);
      chk("roll_code",   32'(kb.key_code), 32'd9);
      release_all();
      tick(3);
      chk("relb_held1", 32'(kb.key_held), 32'd1);
      pressed[2][1] = 1'b1;
      tick(1);
      release_all();
      tick(3);
      chk("relb_held2", 32'(kb.key_held), 32'd1);
      tick(1);
      chk("rel_held",  32'(kb.key_held), 32'd0);
      chk("rel_col",   32'(kb.col), 32'h0000000B);
      chk("rel_code",  32'(kb.key_code), 32'd9);

      // Press bounce: two low samples then high.
      pressed[2][1] = 1'b1;
      tick(5);
      release_all();
      tick(1);
      chk("bnc_pulses", 32'(pulses), 32'd1);
      chk("bnc_held",   32'(kb.key_held), 32'd0);
      chk("bnc_code",   32'(kb.key_code), 32'd9);
      chk("bnc_col",    32'(kb.col), 32'h0000000B);

      // Rows 1 and 3 on column 0 together: row 1 wins.
      pressed[1][0] = 1'b1;
      pressed[3][0] = 1'b1;
      tick(5);
      chk("multi_early", 32'(pulses), 32'd1);
      tick(1);
      chk("multi_pulse", 32'(pulses), 32'd2);
      chk("multi_code",  32'(kb.key_code), 32'd4);
      tick(2);
      release_all();
      tick(4);
      chk("multi_rel", 32'(kb.key_held), 32'd0);
      chk("multi_col", 32'(kb.col), 32'h0000000D);

      // Reset while held, with a scan tick on the same edge.
      pressed[2][1] = 1'b1;
      tick(4);
      chk("pre_rst_code", 32'(kb.key_code), 32'd9);
      chk("pre_rst_held", 32'(kb.key_held), 32'd1);
      tick(2);
      @(negedge clk);
      rst = 1'b1;
      ce  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ce  = 1'b0;
      #2;
      chk("hrst_col",  32'(kb.col),      32'h0000000E);
      chk("hrst_code", 32'(kb.key_code), 32'd0);
      chk("hrst_held", 32'(kb.key_held), 32'd0);
      chk("hrst_vld",  32'(kb.key_vld),  32'd0);
      tick(8);
      chk("after_rst_pulses", 32'(pulses), 32'd4);
      chk("after_rst_code",   32'(kb.key_code), 32'd9);
      release_all();
      tick(5);
      chk("end_held", 32'(kb.key_held), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
